// File: rtl/fp_issue_ctrl_if.sv
// Handshake bundle between EX-stage pipeline, the FP issue sequencer and falu.
// The slave modport is the sequencer's view; master is the pipeline/falu side.
interface fp_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int FLAGW = 5,
  parameter int CNTW  = 16
);
  logic             fp_req;
  logic [1:0]       op_code_in;
  logic [WIDTH-1:0] op_a_in;
  logic [WIDTH-1:0] op_b_in;
  logic             kill;
  logic             flags_clr;
  logic             falu_start;
  logic [WIDTH-1:0] falu_op_a;
  logic [WIDTH-1:0] falu_op_b;
  logic [1:0]       falu_op_code;
  logic             falu_valid;
  logic [WIDTH-1:0] falu_result;
  logic [FLAGW-1:0] falu_flags;
  logic             fp_stall;
  logic             fp_done;
  logic [WIDTH-1:0] fp_result;
  logic [FLAGW-1:0] fp_flags_sticky;
  logic             fp_timeout;
  logic             busy;
  logic [CNTW-1:0]  op_count;

  modport slave (
    input  fp_req, op_code_in, op_a_in, op_b_in, kill, flags_clr,
           falu_valid, falu_result, falu_flags,
    output falu_start, falu_op_a, falu_op_b, falu_op_code, fp_stall, fp_done,
           fp_result, fp_flags_sticky, fp_timeout, busy, op_count
  );

  modport master (
    output fp_req, op_code_in, op_a_in, op_b_in, kill, flags_clr,
           falu_valid, falu_result, falu_flags,
    input  falu_start, falu_op_a, falu_op_b, falu_op_code, fp_stall, fp_done,
           fp_result, fp_flags_sticky, fp_timeout, busy, op_count
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// EX-stage sequencer for the multi-cycle falu: capture, start pulse, stall,
// result/flag return, kill-drain and timeout handling.
module fp_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int FLAGW   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input logic           clk,
  input logic           reset,
  fp_issue_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  // One spare bit so a kill taken at the last WAIT cycle cannot wrap in DRAIN.
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [FLAGW-1:0] NV    = FLAGW'(1) << (FLAGW - 1);
  localparam logic [WIDTH-1:0] QNAN  = WIDTH'(32'h7FC0_0000);

  state_t           state, nxt;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [1:0]       op_code;
  logic [FLAGW-1:0] sticky, sticky_base;
  logic             tmo_err;
  logic [CNTW-1:0]  count;
  logic             capture, wait_load, wait_tmo, drain_tmo, expired;

  assign expired   = (timer >= TLAST);
  assign capture   = (state == IDLE) && bus.fp_req && !bus.kill;
  assign wait_load = (state == WAIT) && bus.falu_valid;
  assign wait_tmo  = (state == WAIT) && !bus.falu_valid && !bus.kill && expired;
  assign drain_tmo = (state == DRAIN) && !bus.falu_valid && expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (capture) nxt = ISSUE;
      ISSUE: nxt = bus.kill ? DRAIN : WAIT;
      WAIT: begin
        if (bus.falu_valid)  nxt = DONE;
        else if (bus.kill)   nxt = DRAIN;
        else if (expired)    nxt = DONE;
      end
      DONE:  nxt = IDLE;
      DRAIN: if (bus.falu_valid || expired) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    bus.falu_start = (state == ISSUE);
    bus.fp_done    = (state == DONE);
    bus.busy       = (state != IDLE);
    bus.fp_stall   = reset && (capture || (state == ISSUE) || (state == WAIT) ||
                               ((state == DRAIN) && bus.fp_req));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
    end else begin
      if (state == ISSUE)                         timer <= '0;
      else if (state == WAIT || state == DRAIN)   timer <= timer + 1'b1;
      if (capture) begin
        op_a    <= bus.op_a_in;
        op_b    <= bus.op_b_in;
        op_code <= bus.op_code_in;
      end
    end
  end

  // A clear coinciding with a result load keeps only the new flags.
  assign sticky_base = bus.flags_clr ? '0 : sticky;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result  <= '0;
      sticky  <= '0;
      tmo_err <= 1'b0;
      count   <= '0;
    end else begin
      if (wait_load)     result <= bus.falu_result;
      else if (wait_tmo) result <= QNAN;

      if (wait_load)     sticky <= sticky_base | bus.falu_flags;
      else if (wait_tmo) sticky <= sticky_base | NV;
      else               sticky <= sticky_base;

      if (wait_tmo || drain_tmo) tmo_err <= 1'b1;
      else if (bus.flags_clr)    tmo_err <= 1'b0;

      if (state == DONE) count <= count + 1'b1;
    end
  end

  assign bus.falu_op_a       = op_a;
  assign bus.falu_op_b       = op_b;
  assign bus.falu_op_code    = op_code;
  assign bus.fp_result       = result;
  assign bus.fp_flags_sticky = sticky;
  assign bus.fp_timeout      = tmo_err;
  assign bus.op_count        = count;
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl: issue latency, back-to-back, kill/drain,
// timeout, sticky flag clearing and async reset mid-operation.
module tb_fp_issue_ctrl;
  localparam int WIDTH = 32, FLAGW = 5, CNTW = 16, TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_issue_ctrl_if #(.WIDTH(WIDTH), .FLAGW(FLAGW), .CNTW(CNTW)) bus ();

  fp_issue_ctrl #(.WIDTH(WIDTH), .FLAGW(FLAGW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.fp_req     = 1'b1;
    bus.op_code_in = op;
    bus.op_a_in    = a;
    bus.op_b_in    = b;
  endtask

  initial begin
    bus.fp_req = 0; bus.op_code_in = 0; bus.op_a_in = 0; bus.op_b_in = 0;
    bus.kill = 0; bus.flags_clr = 0;
    bus.falu_valid = 0; bus.falu_result = 0; bus.falu_flags = 0;

    // Reset state
    repeat (2) @(posedge clk);
    smp;
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.fp_stall, 0);
    chk("rst_start", bus.falu_start, 0);
    chk("rst_done", bus.fp_done, 0);
    chk("rst_result", bus.fp_result, 0);
    chk("rst_sticky", bus.fp_flags_sticky, 0);
    chk("rst_timeout", bus.fp_timeout, 0);
    chk("rst_count", bus.op_count, 0);
    chk("rst_opa", bus.falu_op_a, 0);
    nxt;
    reset = 1'b1;

    // fadd 1.0 + 2.0, falu valid 3 cycles after start
    req(2'b00, 32'h3F80_0000, 32'h4000_0000);                    // c0
    smp; chk("add_c0_stall", bus.fp_stall, 1); chk("add_c0_start", bus.falu_start, 0);
    nxt;                                                         // c1
    smp; chk("add_c1_start", bus.falu_start, 1); chk("add_c1_stall", bus.fp_stall, 1);
    chk("add_opa", bus.falu_op_a, 32'h3F80_0000); chk("add_opb", bus.falu_op_b, 32'h4000_0000);
    chk("add_opcode", bus.falu_op_code, 0);
    nxt;                                                         // c2
    smp; chk("add_c2_stall", bus.fp_stall, 1); chk("add_c2_start", bus.falu_start, 0);
    nxt;                                                         // c3
    smp; chk("add_c3_stall", bus.fp_stall, 1);
    nxt;                                                         // c4
    bus.falu_valid = 1; bus.falu_result = 32'h4040_0000; bus.falu_flags = 5'b00001;
    smp; chk("add_c4_stall", bus.fp_stall, 1); chk("add_c4_done", bus.fp_done, 0);
    nxt;                                                         // c5 DONE, fp_req still held
    bus.falu_valid = 0;
    smp; chk("add_done", bus.fp_done, 1); chk("add_result", bus.fp_result, 32'h4040_0000);
    chk("add_c5_stall", bus.fp_stall, 0); chk("add_c5_start", bus.falu_start, 0);
    chk("add_c5_count", bus.op_count, 0);

    // Back-to-back fmul straight after DONE
    nxt;
    req(2'b10, 32'h4040_0000, 32'h4000_0000);
    smp; chk("mul_c0_stall", bus.fp_stall, 1); chk("mul_c0_start", bus.falu_start, 0);
    chk("add_count", bus.op_count, 1); chk("add_sticky", bus.fp_flags_sticky, 5'b00001);
    nxt;
    smp; chk("mul_start", bus.falu_start, 1); chk("mul_opcode", bus.falu_op_code, 2);
    chk("mul_opa", bus.falu_op_a, 32'h4040_0000);
    nxt;
    bus.falu_valid = 1; bus.falu_result = 32'h40C0_0000; bus.falu_flags = 5'b00100;
    smp; chk("mul_wait_stall", bus.fp_stall, 1);
    nxt;
    bus.falu_valid = 0;
    smp; chk("mul_done", bus.fp_done, 1); chk("mul_no_restart", bus.falu_start, 0);
    chk("mul_result", bus.fp_result, 32'h40C0_0000);
    chk("mul_sticky", bus.fp_flags_sticky, 5'b00101); chk("mul_done_stall", bus.fp_stall, 0);

    // fdiv killed in WAIT; the next instruction waits out the drain
    nxt;
    req(2'b11, 32'h1111_1111, 32'h2222_2222);
    smp; chk("mul_count", bus.op_count, 2); chk("div_c0_stall", bus.fp_stall, 1);
    nxt;
    smp; chk("div_start", bus.falu_start, 1);
    nxt;
    bus.kill = 1;
    smp; chk("kill_stall", bus.fp_stall, 1); chk("kill_done", bus.fp_done, 0);
    nxt;
    bus.kill = 0;
    req(2'b01, 32'h40A0_0000, 32'h3F80_0000);
    smp; chk("drain_stall", bus.fp_stall, 1); chk("drain_busy", bus.busy, 1);
    chk("drain_done", bus.fp_done, 0); chk("drain_start", bus.falu_start, 0);
    nxt;
    bus.falu_valid = 1; bus.falu_result = 32'hDEAD_BEEF; bus.falu_flags = 5'b01000;
    smp; chk("drain_v_stall", bus.fp_stall, 1); chk("drain_v_done", bus.fp_done, 0);
    nxt;
    bus.falu_valid = 0;
    smp; chk("post_drain_busy", bus.busy, 0); chk("post_drain_stall", bus.fp_stall, 1);
    chk("post_drain_done", bus.fp_done, 0); chk("drain_result", bus.fp_result, 32'h40C0_0000);
    chk("drain_sticky", bus.fp_flags_sticky, 5'b00101);
    nxt;
    smp; chk("sub_start", bus.falu_start, 1); chk("sub_opa", bus.falu_op_a, 32'h40A0_0000);
    chk("sub_opcode", bus.falu_op_code, 1);
    nxt;
    bus.falu_valid = 1; bus.falu_result = 32'h4080_0000; bus.falu_flags = 5'b00000;
    nxt;
    bus.falu_valid = 0;
    smp; chk("sub_done", bus.fp_done, 1); chk("sub_result", bus.fp_result, 32'h4080_0000);
    chk("sub_sticky", bus.fp_flags_sticky, 5'b00101);
    nxt;
    bus.fp_req = 0;
    smp; chk("sub_count", bus.op_count, 3); chk("idle_stall", bus.fp_stall, 0);

    // flags_clr coinciding with a result load keeps only the new flags
    nxt;
    req(2'b00, 32'h3F00_0000, 32'h0000_0000);
    nxt;
    nxt;
    bus.falu_valid = 1; bus.falu_result = 32'h3F00_0000; bus.falu_flags = 5'b10000;
    bus.flags_clr = 1;
    nxt;
    bus.falu_valid = 0; bus.flags_clr = 0;
    smp; chk("clr_done", bus.fp_done, 1); chk("clr_sticky", bus.fp_flags_sticky, 5'b10000);
    nxt;
    bus.fp_req = 0; bus.flags_clr = 1;
    nxt;
    bus.flags_clr = 0;
    smp; chk("clr_idle_sticky", bus.fp_flags_sticky, 0); chk("clr_count", bus.op_count, 4);

    // falu never answers: timeout completes with canonical NaN and NV
    nxt;
    req(2'b11, 32'h3F80_0000, 32'h0000_0000);                    // c0
    nxt;                                                         // c1
    repeat (8) nxt;                                              // c9
    smp; chk("tmo_c9_stall", bus.fp_stall, 1); chk("tmo_c9_done", bus.fp_done, 0);
    chk("tmo_c9_flag", bus.fp_timeout, 0);
    nxt;                                                         // c10
    smp; chk("tmo_done", bus.fp_done, 1); chk("tmo_result", bus.fp_result, 32'h7FC0_0000);
    chk("tmo_sticky", bus.fp_flags_sticky, 5'b10000); chk("tmo_flag", bus.fp_timeout, 1);
    nxt;
    bus.fp_req = 0;
    smp; chk("tmo_count", bus.op_count, 5); chk("tmo_busy", bus.busy, 0);
    bus.flags_clr = 1;
    nxt;
    bus.flags_clr = 0;
    smp; chk("tmo_cleared", bus.fp_timeout, 0); chk("tmo_sticky_clr", bus.fp_flags_sticky, 0);

    // Async reset while in WAIT
    nxt;
    req(2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
    nxt;
    nxt;
    smp; chk("rw_busy_pre", bus.busy, 1);
    #1;
    reset = 0; bus.fp_req = 0;
    #1;
    chk("rw_busy", bus.busy, 0); chk("rw_stall", bus.fp_stall, 0);
    chk("rw_start", bus.falu_start, 0); chk("rw_done", bus.fp_done, 0);
    chk("rw_result", bus.fp_result, 0); chk("rw_count", bus.op_count, 0);
    chk("rw_opa", bus.falu_op_a, 0); chk("rw_sticky", bus.fp_flags_sticky, 0);
    nxt;
    reset = 1;
    nxt;
    bus.falu_valid = 1; bus.falu_result = 32'h1234_5678; bus.falu_flags = 5'b11111;
    nxt;
    bus.falu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("late_done", bus.fp_done, 0); chk("late_busy", bus.busy, 0);
      chk("late_result", bus.fp_result, 0); chk("late_sticky", bus.fp_flags_sticky, 0);
      nxt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
Sequencer for the multi-cycle floating-point unit (falu) in the EX stage of the 5-stage RISC-V pipeline. It captures an FP operation presented in EX and issues a single start pulse to falu. It holds the pipeline with a stall while falu computes, then returns the registered result and exception flags. It also handles kill (abort), drain of an orphaned falu operation, timeout, and the accumulated sticky FP flags.

Parameters:
WIDTH, 32, operand/result width
FLAGW, 5, falu flag width {NV,DZ,OF,UF,NX}
TIMEOUT, 64, max WAIT/DRAIN cycles before abort (≥2)
CNTW, 16, completed-op counter width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
fp_req  in  1  FP arithmetic op valid in EX (FPE)
op_code_in  in  2  00 fadd, 01 fsub, 10 fmul, 11 fdiv
op_a_in  in  WIDTH  forwarded SrcA
op_b_in  in  WIDTH  forwarded SrcB
kill  in  1  abort the in-flight op (EX flush)
flags_clr  in  1  clear sticky flags
falu_start  out  1  one-cycle start pulse to falu
falu_op_a  out  WIDTH  registered operand A
falu_op_b  out  WIDTH  registered operand B
falu_op_code  out  2  registered op code
falu_valid  in  1  falu result valid (one-cycle pulse)
falu_result  in  WIDTH  falu result
falu_flags  in  FLAGW  falu flags
fp_stall  out  1  hold F/D/E and insert a bubble into M
fp_done  out  1  result valid this cycle; EX may advance
fp_result  out  WIDTH  registered result
fp_flags_sticky  out  FLAGW  OR-accumulated flags
fp_timeout  out  1  sticky timeout error
busy  out  1  state != IDLE
op_count  out  CNTW  completed ops, wraps

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, operand/op-code registers 0, timer 0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: if fp_req&!kill, latch op_a_in/op_b_in/op_code_in and go to ISSUE. falu_valid is ignored in IDLE.
- ISSUE: falu_start=1 for exactly this cycle. Clear timer. Go to WAIT; go to DRAIN if kill.
- WAIT: timer increments each cycle.
  - falu_valid=1: latch fp_result←falu_result, OR falu_flags into sticky, go to DONE.
  - kill and no valid: go to DRAIN.
  - timer==TIMEOUT-1 and no valid: fp_result←32'h7FC00000, NV flag set in sticky, fp_timeout←1, go to DONE.
  - falu_valid has priority over kill and timeout in the same cycle.
- DONE: fp_done=1 for one cycle. op_count+1. Go to IDLE unconditionally. fp_req seen in DONE is the same instruction and is not re-issued.
- DRAIN: wait for falu_valid (result discarded, flags not accumulated) or for timer==TIMEOUT-1. Timeout in DRAIN sets fp_timeout. Go to IDLE; no fp_done.
- fp_stall = (IDLE & fp_req & !kill) | ISSUE | WAIT | (DRAIN & fp_req). fp_stall=0 in DONE. Combinational from state and inputs.
- Latency: with falu valid N cycles after start, fp_req at cycle 0 gives falu_start at cycle 1, fp_done at cycle N+2. Stall covers cycles 0..N+1.
- flags_clr: clears sticky flags and fp_timeout. If a DONE-load happens in the same cycle, the register takes only the new flags.
- fp_result holds its value until the next completion.
- op_count wraps from 2^CNTW-1 to 0.
- Reset mid-operation returns to IDLE immediately. A falu_valid arriving later is ignored.

Test Plan:
- Reset then fadd 3F800000+40000000, falu valid 3 cycles after start → start at cycle 1; stall cycles 0–4; fp_done at cycle 5 with 40400000; op_count=1.
- Back-to-back: fp_req held through DONE, then a new op in the next cycle → exactly one start per op; op_count=2.
- kill during WAIT, falu_valid 2 cycles later, new fp_req meanwhile → DRAIN; stall held; no fp_done; old result discarded; new op issues after the drain.
- falu never valid, TIMEOUT=8 → fp_done at cycle 10 with 7FC00000; sticky NV=1; fp_timeout=1.
- falu_flags=5'b00001 then 5'b00100 on two ops → sticky=5'b00101. flags_clr together with a third op's done carrying 5'b10000 → sticky=5'b10000.
- Async reset asserted while in WAIT → all outputs 0 immediately; late falu_valid ignored; fp_done never asserted.
